// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared encodings and helpers for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

    // Tuse value meaning "this source operand is not read"
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles until the producing instruction has its result available
    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    // Default mult/div latencies, shared with the mult/div datapath
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // RAW hazard between one source operand in D and one producer downstream.
    // Register $0 never carries a dependency, and an unused operand never stalls.
    function automatic logic raw_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wa,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && (tuse != TUSE_NONE) && (src == wa) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // Operand / producer information from D, E and M
    logic [4:0]       rs_D;
    logic [4:0]       rt_D;
    logic [1:0]       tuse_rs_D;
    logic [1:0]       tuse_rt_D;
    logic [4:0]       wa_E;
    logic [1:0]       tnew_E;
    logic [4:0]       wa_M;
    logic [1:0]       tnew_M;
    logic             md_start_E;
    logic             md_is_div_E;
    logic             md_use_D;
    logic             dm_wait_M;

    // Pipeline register controls and status
    logic             pc_en;
    logic             fd_en;
    logic             de_en;
    logic             de_flush;
    logic             em_en;
    logic             mw_flush;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: supplies instruction info, consumes controls
    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, wa_E, tnew_E, wa_M, tnew_M,
               md_start_E, md_is_div_E, md_use_D, dm_wait_M,
        input  pc_en, fd_en, de_en, de_flush, em_en, mw_flush, md_busy, stall_cnt
    );

    // Controller side
    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, wa_E, tnew_E, wa_M, tnew_M,
               md_start_E, md_is_div_E, md_use_D, dm_wait_M,
        output pc_en, fd_en, de_en, de_flush, em_en, mw_flush, md_busy, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// rtl/pipe_hazard_ctrl_md_busy_tracker.sv - mult/div busy FSM with latency countdown
module pipe_hazard_ctrl_md_busy_tracker
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_i,
    input  logic md_is_div_i,
    input  logic dm_wait_i,
    output logic md_busy_o
);

    localparam int LAT_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = ($clog2(LAT_MAX + 1) > 4) ? $clog2(LAT_MAX + 1) : 4;

    md_state_e     state_q;
    logic [CW-1:0] md_cnt_q;
    logic          md_busy_q;

    // Start is only taken when E actually advances (no freeze); the countdown
    // keeps running through freezes because the unit computes regardless.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_start_i && !dm_wait_i) begin
                        md_cnt_q  <= md_is_div_i ? CW'(DIV_LAT) : CW'(MULT_LAT);
                        state_q   <= MD_BUSY;
                        md_busy_q <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    md_cnt_q <= md_cnt_q - CW'(1);
                    if (md_cnt_q == CW'(1)) begin
                        state_q   <= MD_IDLE;
                        md_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= MD_IDLE;
                    md_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign md_busy_o = md_busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/freeze sequencer with stall-cycle counter
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);

    logic             md_busy;
    logic             hz_rs;
    logic             hz_rt;
    logic             md_stall;
    logic             stall;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    pipe_hazard_ctrl_md_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_tracker (
        .clk         (clk),
        .reset       (reset),
        .md_start_i  (bus.md_start_E),
        .md_is_div_i (bus.md_is_div_E),
        .dm_wait_i   (bus.dm_wait_M),
        .md_busy_o   (md_busy)
    );

    // Hazard detection and enable/flush muxing; a memory freeze outranks any stall
    always_comb begin
        hz_rs    = raw_hazard(bus.rs_D, bus.tuse_rs_D, bus.wa_E, bus.tnew_E)
                 | raw_hazard(bus.rs_D, bus.tuse_rs_D, bus.wa_M, bus.tnew_M);
        hz_rt    = raw_hazard(bus.rt_D, bus.tuse_rt_D, bus.wa_E, bus.tnew_E)
                 | raw_hazard(bus.rt_D, bus.tuse_rt_D, bus.wa_M, bus.tnew_M);
        md_stall = bus.md_use_D && (md_busy || bus.md_start_E);
        stall    = hz_rs || hz_rt || md_stall;
        freeze   = bus.dm_wait_M;

        bus.pc_en    = 1'b1;
        bus.fd_en    = 1'b1;
        bus.de_en    = 1'b1;
        bus.de_flush = 1'b0;
        bus.em_en    = 1'b1;
        bus.mw_flush = 1'b0;
        if (freeze) begin
            bus.pc_en    = 1'b0;
            bus.fd_en    = 1'b0;
            bus.de_en    = 1'b0;
            bus.em_en    = 1'b0;
            bus.mw_flush = 1'b1;
        end else if (stall) begin
            bus.pc_en    = 1'b0;
            bus.fd_en    = 1'b0;
            bus.de_flush = 1'b1;
        end
    end

    // Saturating count of stalled or frozen cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall || freeze) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.md_busy   = md_busy;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (10),
        .CNT_W    (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: remaining busy cycles of the mult/div unit and stall tally
    int m_rem = 0;
    int m_cnt = 0;
    bit seen_reset = 1'b0;

    function automatic bit hz(input int src, input int tuse, input int wa, input int tnew);
        return (src != 0) && (tuse != 3) && (src == wa) && (tuse < tnew);
    endfunction

    function automatic bit model_stall();
        bit d;
        d = hz(bus.rs_D, bus.tuse_rs_D, bus.wa_E, bus.tnew_E) || hz(bus.rs_D, bus.tuse_rs_D, bus.wa_M, bus.tnew_M)
         || hz(bus.rt_D, bus.tuse_rt_D, bus.wa_E, bus.tnew_E) || hz(bus.rt_D, bus.tuse_rt_D, bus.wa_M, bus.tnew_M);
        return d || (bus.md_use_D && ((m_rem > 0) || bus.md_start_E));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_rem      <= 0;
            m_cnt      <= 0;
            seen_reset <= 1'b1;
        end else begin
            if (model_stall() || bus.dm_wait_M) m_cnt <= (m_cnt >= 15) ? 15 : m_cnt + 1;
            if (m_rem > 0) m_rem <= m_rem - 1;
            else if (bus.md_start_E && !bus.dm_wait_M) m_rem <= bus.md_is_div_E ? 10 : 5;
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (seen_reset) begin
            bit st;
            bit fr;
            st = model_stall();
            fr = bus.dm_wait_M;
            chk("pc_en",     32'(bus.pc_en),     32'(!fr && !st));
            chk("fd_en",     32'(bus.fd_en),     32'(!fr && !st));
            chk("de_en",     32'(bus.de_en),     32'(!fr));
            chk("de_flush",  32'(bus.de_flush),  32'(!fr && st));
            chk("em_en",     32'(bus.em_en),     32'(!fr));
            chk("mw_flush",  32'(bus.mw_flush),  32'(fr));
            chk("md_busy",   32'(bus.md_busy),   32'(m_rem > 0));
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        bus.rs_D = 5'd0; bus.rt_D = 5'd0;
        bus.tuse_rs_D = 2'd3; bus.tuse_rt_D = 2'd3;
        bus.wa_E = 5'd0; bus.tnew_E = 2'd0;
        bus.wa_M = 5'd0; bus.tnew_M = 2'd0;
        bus.md_start_E = 1'b0; bus.md_is_div_E = 1'b0;
        bus.md_use_D = 1'b0; bus.dm_wait_M = 1'b0;
    endtask

    task automatic count_busy(input string name, input int req);
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.md_busy === 1'b1) n++;
            step(1);
        end
        chk(name, 32'(n), 32'(req));
    endtask

    initial begin
        reset = 1'b1;
        clear_ops();
        step(2);
        reset = 1'b0;
        @(negedge clk);
        chk("lit_reset_busy", 32'(bus.md_busy), 32'd0);
        chk("lit_reset_cnt",  32'(bus.stall_cnt), 32'd0);

        // no hazard
        step(1);
        bus.rs_D = 5'd3; bus.tuse_rs_D = 2'd0; bus.wa_E = 5'd5; bus.tnew_E = 2'd2;
        step(2);
        @(negedge clk);
        chk("lit_nohz_pc", 32'(bus.pc_en), 32'd1);
        chk("lit_nohz_cnt", 32'(bus.stall_cnt), 32'd0);

        // load-use from E
        step(1);
        bus.rs_D = 5'd8; bus.tuse_rs_D = 2'd0; bus.wa_E = 5'd8; bus.tnew_E = 2'd2;
        @(negedge clk);
        chk("lit_lu_pc", 32'(bus.pc_en), 32'd0);
        chk("lit_lu_flush", 32'(bus.de_flush), 32'd1);
        chk("lit_lu_em", 32'(bus.em_en), 32'd1);
        step(1);
        bus.tnew_E = 2'd1; bus.tuse_rs_D = 2'd1;
        @(negedge clk);
        chk("lit_lu_cnt", 32'(bus.stall_cnt), 32'd1);
        chk("lit_lu_clear", 32'(bus.pc_en), 32'd1);

        // hazard from M on rt
        step(1);
        clear_ops();
        bus.rt_D = 5'd9; bus.tuse_rt_D = 2'd1; bus.wa_M = 5'd9; bus.tnew_M = 2'd2;
        step(1);
        clear_ops();
        @(negedge clk);
        chk("lit_m_cnt", 32'(bus.stall_cnt), 32'd2);

        // $0 exemption
        step(1);
        bus.rt_D = 5'd0; bus.wa_M = 5'd0; bus.tnew_M = 2'd1; bus.tuse_rt_D = 2'd0;
        @(negedge clk);
        chk("lit_r0_pc", 32'(bus.pc_en), 32'd1);

        // div with dependent mult/div op waiting in D
        step(1);
        clear_ops();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b1;
        step(1);
        bus.md_start_E = 1'b0; bus.md_use_D = 1'b1;
        count_busy("lit_div_busy", 10);
        @(negedge clk);
        chk("lit_div_cnt", 32'(bus.stall_cnt), 32'd10);

        // mult
        step(1);
        bus.md_use_D = 1'b0;
        bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b0;
        step(1);
        bus.md_start_E = 1'b0;
        count_busy("lit_mult_busy", 5);

        // memory freeze over a hazard, with a mult held in E
        bus.rs_D = 5'd8; bus.tuse_rs_D = 2'd0; bus.wa_E = 5'd8; bus.tnew_E = 2'd2;
        bus.dm_wait_M = 1'b1; bus.md_start_E = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_frz_pc", 32'(bus.pc_en), 32'd0);
            chk("lit_frz_em", 32'(bus.em_en), 32'd0);
            chk("lit_frz_mw", 32'(bus.mw_flush), 32'd1);
            chk("lit_frz_busy", 32'(bus.md_busy), 32'd0);
            step(1);
        end
        bus.dm_wait_M = 1'b0;
        @(negedge clk);
        chk("lit_post_frz_flush", 32'(bus.de_flush), 32'd1);
        step(1);
        bus.md_start_E = 1'b0;
        clear_ops();
        @(negedge clk);
        chk("lit_post_frz_busy", 32'(bus.md_busy), 32'd1);
        step(6);

        // reset in the middle of a div
        bus.md_start_E = 1'b1; bus.md_is_div_E = 1'b1;
        step(1);
        bus.md_start_E = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        chk("lit_rst_busy", 32'(bus.md_busy), 32'd0);
        chk("lit_rst_cnt", 32'(bus.stall_cnt), 32'd0);

        // saturation
        step(1);
        bus.rs_D = 5'd4; bus.tuse_rs_D = 2'd0; bus.wa_M = 5'd4; bus.tnew_M = 2'd1;
        step(20);
        @(negedge clk);
        chk("lit_sat_cnt", 32'(bus.stall_cnt), 32'd15);
        step(1);
        clear_ops();
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
